// File: rtl/wptr_full.sv
// Write-side pointer, memory address/enable and full/level/almost-full/overflow flags for an async FIFO.
// Optional almost-full comparator is built only when ASYNC_FIFO_ALMOST_FULL_EN is defined.
module wptr_full #(
    parameter int ADDR_WIDTH = 6,
    parameter int AF_THRESH  = 2**ADDR_WIDTH - 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  winc,
    input  logic [ADDR_WIDTH:0]   wq2_rptr,
    output logic                  wen,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [ADDR_WIDTH:0]   wptr,
    output logic                  wfull,
    output logic [ADDR_WIDTH:0]   wlevel,
    output logic                  walmost_full,
    output logic                  wovf
);

    localparam int PW = ADDR_WIDTH + 1;

    if ((AF_THRESH < 1) || (AF_THRESH > 2**ADDR_WIDTH)) begin : g_bad_thresh
        $error("wptr_full: AF_THRESH out of range");
    end

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [PW-1:0] wbin_r;
    logic [PW-1:0] wbin_next_s;
    logic [PW-1:0] wgray_next_s;
    logic [PW-1:0] rbin_s;
    logic [PW-1:0] full_ptr_s;
    logic [PW-1:0] level_next_s;
    logic          full_next_s;

    // Next-state pointer, full compare and occupancy from the synchronized read pointer.
    always_comb begin
        wen          = 1'b0;
        wbin_next_s  = wbin_r;
        wgray_next_s = {PW{1'b0}};
        rbin_s       = gray2bin(wq2_rptr);
        full_ptr_s   = {~wq2_rptr[ADDR_WIDTH:ADDR_WIDTH-1], wq2_rptr[ADDR_WIDTH-2:0]};
        full_next_s  = 1'b0;
        level_next_s = {PW{1'b0}};
        if (rst) begin
            wen = 1'b0;
        end else begin
            wen = winc & ~wfull;
        end
        wbin_next_s  = wbin_r + {{(PW-1){1'b0}}, wen};
        wgray_next_s = wbin_next_s ^ (wbin_next_s >> 1);
        full_next_s  = (wgray_next_s == full_ptr_s);
        level_next_s = wbin_next_s - rbin_s;
    end

    assign waddr = wbin_r[ADDR_WIDTH-1:0];

    // Pointer and status registers; overflow is sticky until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wbin_r <= {PW{1'b0}};
            wptr   <= {PW{1'b0}};
            wfull  <= 1'b0;
            wlevel <= {PW{1'b0}};
            wovf   <= 1'b0;
        end else begin
            wbin_r <= wbin_next_s;
            wptr   <= wgray_next_s;
            wfull  <= full_next_s;
            wlevel <= level_next_s;
            wovf   <= wovf | (winc & wfull);
        end
    end

`ifdef ASYNC_FIFO_ALMOST_FULL_EN
    // Almost-full tracks the same next-state level as wlevel.
    always_ff @(posedge clk) begin
        if (rst) begin
            walmost_full <= 1'b0;
        end else begin
            walmost_full <= (level_next_s >= PW'(AF_THRESH));
        end
    end
`else
    assign walmost_full = 1'b0;
`endif

endmodule

// File: tb/tb_wptr_full.sv
// Self-checking bench for wptr_full against an occupancy-count reference model.
module tb_wptr_full;

    localparam int AW    = 6;
    localparam int PW    = 7;
    localparam int DEPTH = 64;
    localparam int AF    = 60;
`ifdef ASYNC_FIFO_ALMOST_FULL_EN
    localparam bit AF_EN = 1'b1;
`else
    localparam bit AF_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          winc;
    logic [PW-1:0] wq2_rptr;
    logic          wen;
    logic [AW-1:0] waddr;
    logic [PW-1:0] wptr;
    logic          wfull;
    logic [PW-1:0] wlevel;
    logic          walmost_full;
    logic          wovf;

    wptr_full #(.ADDR_WIDTH(AW), .AF_THRESH(AF)) dut (
        .clk(clk), .rst(rst), .winc(winc), .wq2_rptr(wq2_rptr), .wen(wen),
        .waddr(waddr), .wptr(wptr), .wfull(wfull), .wlevel(wlevel),
        .walmost_full(walmost_full), .wovf(wovf)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: counts of writes/reads modulo 2*DEPTH, occupancy is their difference.
    int m_wbin = 0;
    int m_rbin = 0;
    int m_level = 0;
    bit m_full = 1'b0;
    bit m_af = 1'b0;
    bit m_ovf = 1'b0;
    logic obs_wen;
    bit   exp_wen;

    function automatic logic [PW-1:0] to_gray(input int b);
        logic [PW-1:0] v;
        v = PW'(b);
        return v ^ (v >> 1);
    endfunction

    // One clock: drive inputs, capture wen before the edge, advance model at the edge.
    task automatic cycle(input bit r, input bit w, input int rb);
        rst = r;
        winc = w;
        m_rbin = rb % 128;
        wq2_rptr = to_gray(m_rbin);
        #1;
        obs_wen = wen;
        exp_wen = w && !m_full && !r;
        @(posedge clk);
        if (r) begin
            m_wbin = 0; m_level = 0; m_full = 0; m_af = 0; m_ovf = 0;
        end else begin
            if (w && m_full) m_ovf = 1'b1;
            if (exp_wen) m_wbin = (m_wbin + 1) % 128;
            m_level = (m_wbin - m_rbin + 128) % 128;
            m_full = (m_level == DEPTH);
            m_af = AF_EN && (m_level >= AF);
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            cycle(1'b1, 1'b1, 0);
            n_tests++; if (obs_wen !== 1'b0) begin n_fail++; $display("FAIL reset_wen got %b want 0", obs_wen); end
        end
        n_tests++; if (wptr !== 7'h00) begin n_fail++; $display("FAIL reset_wptr got %h want 00", wptr); end
        n_tests++; if (waddr !== 6'h00) begin n_fail++; $display("FAIL reset_waddr got %h want 00", waddr); end
        n_tests++; if (wfull !== 1'b0) begin n_fail++; $display("FAIL reset_wfull got %b want 0", wfull); end
        n_tests++; if (wlevel !== 7'd0) begin n_fail++; $display("FAIL reset_wlevel got %0d want 0", wlevel); end
        n_tests++; if (wovf !== 1'b0) begin n_fail++; $display("FAIL reset_wovf got %b want 0", wovf); end
        n_tests++; if (walmost_full !== 1'b0) begin n_fail++; $display("FAIL reset_af got %b want 0", walmost_full); end
        cycle(1'b0, 1'b1, 0);
        n_tests++; if (wptr !== 7'h01) begin n_fail++; $display("FAIL reset_first_wptr got %h want 01", wptr); end
    endtask

    task automatic test_fill();
        logic [AW-1:0] ea;
        cycle(1'b1, 1'b0, 0);
        for (int i = 0; i < DEPTH; i++) begin
            ea = AW'(i);
            n_tests++; if (waddr !== ea) begin n_fail++; $display("FAIL fill_waddr got %h want %h", waddr, ea); end
            cycle(1'b0, 1'b1, 0);
            n_tests++; if (obs_wen !== 1'b1) begin n_fail++; $display("FAIL fill_wen got %b want 1", obs_wen); end
            n_tests++; if (wptr !== to_gray(i + 1)) begin n_fail++; $display("FAIL fill_wptr got %h want %h", wptr, to_gray(i + 1)); end
        end
        n_tests++; if (wptr !== 7'h60) begin n_fail++; $display("FAIL fill_final_wptr got %h want 60", wptr); end
        n_tests++; if (wfull !== 1'b1) begin n_fail++; $display("FAIL fill_wfull got %b want 1", wfull); end
        n_tests++; if (wlevel !== 7'd64) begin n_fail++; $display("FAIL fill_wlevel got %0d want 64", wlevel); end
    endtask

    task automatic test_overflow();
        cycle(1'b0, 1'b1, 0);
        n_tests++; if (obs_wen !== 1'b0) begin n_fail++; $display("FAIL ovf_wen got %b want 0", obs_wen); end
        n_tests++; if (wptr !== 7'h60) begin n_fail++; $display("FAIL ovf_wptr got %h want 60", wptr); end
        n_tests++; if (wovf !== 1'b1) begin n_fail++; $display("FAIL ovf_set got %b want 1", wovf); end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 0);
            n_tests++; if (wovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b want 1", wovf); end
        end
    endtask

    task automatic test_release();
        cycle(1'b0, 1'b0, 1);
        n_tests++; if (wfull !== 1'b0) begin n_fail++; $display("FAIL release_wfull got %b want 0", wfull); end
        n_tests++; if (wlevel !== 7'd63) begin n_fail++; $display("FAIL release_wlevel got %0d want 63", wlevel); end
        cycle(1'b0, 1'b1, 1);
        n_tests++; if (obs_wen !== 1'b1) begin n_fail++; $display("FAIL release_wen got %b want 1", obs_wen); end
        n_tests++; if (wfull !== 1'b1) begin n_fail++; $display("FAIL refill_wfull got %b want 1", wfull); end
        n_tests++; if (wlevel !== 7'd64) begin n_fail++; $display("FAIL refill_wlevel got %0d want 64", wlevel); end
    endtask

    task automatic test_wrap();
        bit saw_40;
        saw_40 = 1'b0;
        cycle(1'b1, 1'b0, 0);
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 0);
        cycle(1'b0, 1'b0, 64);
        n_tests++; if (wfull !== 1'b0) begin n_fail++; $display("FAIL wrap_drain_wfull got %b want 0", wfull); end
        n_tests++; if (wlevel !== 7'd0) begin n_fail++; $display("FAIL wrap_drain_wlevel got %0d want 0", wlevel); end
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b0, 1'b1, 64);
            if (wptr === 7'h40) saw_40 = 1'b1;
            n_tests++; if (wlevel !== PW'(i + 1)) begin n_fail++; $display("FAIL wrap_wlevel got %0d want %0d", wlevel, i + 1); end
        end
        n_tests++; if (saw_40 !== 1'b1) begin n_fail++; $display("FAIL wrap_saw_40 got %b want 1", saw_40); end
        n_tests++; if (wptr !== 7'h00) begin n_fail++; $display("FAIL wrap_wptr got %h want 00", wptr); end
        n_tests++; if (waddr !== 6'h00) begin n_fail++; $display("FAIL wrap_waddr got %h want 00", waddr); end
        n_tests++; if (wfull !== 1'b1) begin n_fail++; $display("FAIL wrap_wfull got %b want 1", wfull); end
    endtask

    task automatic test_almost_full();
        cycle(1'b1, 1'b0, 0);
        for (int i = 0; i < AF - 1; i++) cycle(1'b0, 1'b1, 0);
        n_tests++; if (walmost_full !== 1'b0) begin n_fail++; $display("FAIL af_59 got %b want 0", walmost_full); end
        cycle(1'b0, 1'b1, 0);
        n_tests++; if (walmost_full !== AF_EN) begin n_fail++; $display("FAIL af_60 got %b want %b", walmost_full, AF_EN); end
        n_tests++; if (wlevel !== 7'd60) begin n_fail++; $display("FAIL af_wlevel got %0d want 60", wlevel); end
    endtask

    task automatic test_random();
        bit r, w;
        int rb, lvl;
        logic [AW-1:0] ea;
        cycle(1'b1, 1'b0, 0);
        for (int i = 0; i < 600; i++) begin
            r = ($urandom_range(0, 149) == 0);
            w = ($urandom_range(0, 3) != 0);
            lvl = (m_wbin - m_rbin + 128) % 128;
            if (r) rb = 0;
            else if (lvl > 0 && $urandom_range(0, 1) == 1) rb = m_rbin + 1;
            else rb = m_rbin;
            cycle(r, w, rb);
            ea = AW'(m_wbin % DEPTH);
            n_tests++; if (obs_wen !== exp_wen) begin n_fail++; $display("FAIL rnd_wen cyc %0d got %b want %b", i, obs_wen, exp_wen); end
            n_tests++; if (wptr !== to_gray(m_wbin)) begin n_fail++; $display("FAIL rnd_wptr cyc %0d got %h want %h", i, wptr, to_gray(m_wbin)); end
            n_tests++; if (waddr !== ea) begin n_fail++; $display("FAIL rnd_waddr cyc %0d got %h want %h", i, waddr, ea); end
            n_tests++; if (wfull !== m_full) begin n_fail++; $display("FAIL rnd_wfull cyc %0d got %b want %b", i, wfull, m_full); end
            n_tests++; if (wlevel !== PW'(m_level)) begin n_fail++; $display("FAIL rnd_wlevel cyc %0d got %0d want %0d", i, wlevel, m_level); end
            n_tests++; if (walmost_full !== m_af) begin n_fail++; $display("FAIL rnd_af cyc %0d got %b want %b", i, walmost_full, m_af); end
            n_tests++; if (wovf !== m_ovf) begin n_fail++; $display("FAIL rnd_wovf cyc %0d got %b want %b", i, wovf, m_ovf); end
        end
    endtask

    initial begin
        rst = 1'b1;
        winc = 1'b0;
        wq2_rptr = 7'h00;
        test_reset();
        test_fill();
        test_overflow();
        test_release();
        test_wrap();
        test_almost_full();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
